vn_extractor_fifo: RTL

//  Downstream consumer of the LFSR/entropy source bit stream. Applies von Neumann

---
 rtl/vn_extractor_fifo.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vn_extractor_fifo.sv
// Von Neumann debiaser feeding a WORD_W-bit packer and a DEPTH-word output FIFO.
// Define HEALTH_TEST_EN to add the repetition-count health test on the raw stream.
module vn_extractor_fifo #(
   parameter int WORD_W    = 8,
   parameter int DEPTH     = 4,
   parameter int REP_LIMIT = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   bit_in,
   input  logic                   bit_valid,
   output logic [WORD_W-1:0]      out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] fill_level,
   output logic                   overflow,
   output logic                   health_fail
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WORD_W);

   typedef enum logic {S_FIRST, S_SECOND} pair_state_t;
   pair_state_t state, state_next;

   logic              first_bit;
   logic              take;
   logic              ext_valid;
   logic [CW-1:0]     bit_cnt;
   logic [WORD_W-1:0] shift_reg;
   logic [WORD_W-1:0] push_word;
   logic              push;
   logic              pop;
   logic              full;
   logic              wr_en;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     rd_ptr_next;
   logic [AW:0]       fill_next;
   logic [WORD_W-1:0] mem [DEPTH];

   // A tripped health test freezes extraction; the FIFO keeps draining.
   assign take = bit_valid & ~health_fail;

   always_ff @(posedge clk) begin
      if (rst) state <= S_FIRST;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      ext_valid  = 1'b0;
      case (state)
         S_FIRST:  if (take) state_next = S_SECOND;
         S_SECOND: if (take) begin
            state_next = S_FIRST;
            ext_valid  = (first_bit != bit_in);
         end
         default:  state_next = S_FIRST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state == S_FIRST && take) first_bit <= bit_in;
   end

   // Extracted bit is the first bit of the pair (10 -> 1, 01 -> 0).
   assign push_word = {shift_reg[WORD_W-2:0], first_bit};
   assign push      = ext_valid && (bit_cnt == CW'(WORD_W-1));

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (ext_valid) begin
         shift_reg <= push_word;
         bit_cnt   <= push ? '0 : bit_cnt + 1'b1;
      end
   end

   assign out_valid   = (fill_level != '0);
   assign full        = (fill_level == (AW+1)'(DEPTH));
   assign pop         = out_valid & out_ready;
   assign wr_en       = push & (~full | pop);
   assign rd_ptr_next = rd_ptr + AW'(pop);
   assign fill_next   = fill_level + (AW+1)'(wr_en) - (AW+1)'(pop);

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_word;
   end

   // out_data is a registered copy of the next head; it holds when the FIFO empties.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         overflow   <= 1'b0;
         out_data   <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr     <= rd_ptr_next;
         fill_level <= fill_next;
         if (push & full & ~pop) overflow <= 1'b1;
         if (fill_next != '0)
            out_data <= (wr_en && wr_ptr == rd_ptr_next) ? push_word : mem[rd_ptr_next];
      end
   end

`ifdef HEALTH_TEST_EN
   localparam int RW = $clog2(REP_LIMIT+1);
   logic [RW-1:0] run_cnt;
   logic [RW-1:0] run_next;
   logic          last_bit;

   // Run length saturates at REP_LIMIT so it can never wrap back below the threshold.
   always_comb begin
      run_next = RW'(1);
      if (run_cnt != '0 && bit_in == last_bit)
         run_next = (run_cnt == RW'(REP_LIMIT)) ? run_cnt : run_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt     <= '0;
         health_fail <= 1'b0;
      end else if (bit_valid) begin
         run_cnt  <= run_next;
         last_bit <= bit_in;
         if (run_next == RW'(REP_LIMIT)) health_fail <= 1'b1;
      end
   end
`else
   assign health_fail = 1'b0;
`endif

endmodule
